mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences the data-memory access described by the EX/MEM pipeline stage outputs (mtype, rw, width, wr_data, rdtype, addr) onto a single-outstanding req/ack data bus. It generates byte strobes and write-lane replication, extracts and extends read data, and stalls the pipeline until the access completes. It also flags misaligned accesses, bus errors and timeouts. It sits between the EX/MEM register and the data-memory/bus port, and feeds MEM writeback.

Parameters:
TIMEOUT_CYCLES, 255, number of ACCESS cycles without ack/err before the access is aborted (≥1)
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mtype_i  input  1  memory op present in MEM stage
mem_rw_i  input  1  0=load, 1=store
mem_width_i  input  2  00 byte, 01 half, 10 word, 11 illegal
mem_wr_data_i  input  32  store data (low bits significant)
mem_rdtype_i  input  1  0=sign-extend, 1=zero-extend
mem_addr_i  input  32  byte address
stall_o  output  1  hold EX/MEM and upstream stages
rd_data_o  output  32  extended load result
rd_valid_o  output  1  load result valid (1-cycle pulse)
err_o  output  1  access failed (1-cycle pulse)
err_cause_o  output  2  01 misaligned/illegal, 10 bus error, 11 timeout
bus_req_o  output  1  bus request, held until ack/err/timeout
bus_we_o  output  1  write enable
bus_addr_o  output  32  word address {addr[31:2],2'b00}
bus_be_o  output  4  byte enables
bus_wdata_o  output  32  lane-replicated store data
bus_ack_i  input  1  access complete
bus_rdata_i  input  32  read data, valid with ack
bus_err_i  input  1  bus error, valid as completion

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; timeout counter 0. Reset asserted mid-ACCESS drops bus_req_o immediately; no completion pulse is produced.
- FSM states:
  - IDLE: if mtype_i=1, accept the op.
    - Legal op: latch the bus fields (addr, we, be, wdata, width, rdtype, addr[1:0]), set bus_req_o, go to ACCESS.
    - Misaligned op (half with addr[0]=1, word with addr[1:0]≠0) or width=11: no request; go to DONE with cause 01.
  - ACCESS: bus_req_o=1 and all bus outputs held stable. The counter increments each cycle.
    - bus_ack_i=1: DONE. If bus_err_i is also 1, cause=10.
    - bus_err_i=1 alone: DONE with cause 10.
    - Counter reaches TIMEOUT_CYCLES-1 with no ack/err: DONE with cause 11.
    - Ack/err takes priority over timeout in the same cycle.
    - bus_req_o falls on the transition out of ACCESS.
  - DONE: single cycle.
    - Pulse err_o with err_cause_o if an error was recorded. Otherwise, for a load, pulse rd_valid_o with registered rd_data_o.
    - Always go to IDLE. No new op is accepted in DONE; the pipeline advances at the end of this cycle.
- stall_o (combinational) = (IDLE & mtype_i) | ACCESS. It is 0 in DONE.
- Latency: op visible at cycle N; bus_req_o high N+1; ack at N+1+k (k≥0); DONE (result/pulse, stall=0) at N+2+k. Minimum stall is 2 cycles.
- Strobes:
  - byte: 0001<<a[1:0]
  - half: 0011<<{a[1],1'b0}
  - word: 1111
- Write data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Read data: shift bus_rdata_i right by a[1:0]×8, take 8/16/32 bits, then sign- or zero-extend per rdtype. For a word load, rdtype is ignored.
- Stores complete with rd_valid_o=0. err_o and rd_valid_o are never both 1. rd_data_o holds its value outside DONE.
- A bus_ack_i or bus_err_i seen outside ACCESS is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - width codes (W_BYTE, W_HALF, W_WORD)
  - error cause codes (ERR_NONE, ERR_ALIGN, ERR_BUS, ERR_TIMEOUT)
  - FSM state encoding (IDLE, ACCESS, DONE)
- One combinational sub-module, mem_lane_align, generates be/wdata for stores and performs read extraction/extension. It is instantiated once. FSM, latches and counter stay in the top.

Test Plan:
- LB, sign-extend, addr 0x0000_1003; ack one cycle after req with rdata 0x80FF_FF12 -> be 1000, rd_data_o 0xFFFF_FF80, rd_valid_o pulse, total stall 3 cycles.
- LHU, addr 0x0000_2002; rdata 0xBEEF_1234, immediate ack -> bus_addr 0x0000_2000, be 1100, rd_data_o 0x0000_BEEF.
- SW 0xDEAD_BEEF to 0x100, ack after 3 wait cycles -> be 1111, wdata 0xDEAD_BEEF, req held 4 cycles, stall 5 cycles, no rd_valid_o/err_o. SB 0x5A to 0x101 -> be 0010, wdata 0x5A5A_5A5A.
- SH to addr 0x101 and width=11 -> no bus_req_o, err_o pulse with cause 01 one cycle later, stall 1 cycle.
- TIMEOUT_CYCLES=4, no ack -> req drops after 4 ACCESS cycles, err cause 11. Separately, bus_err_i with ack -> cause 10. Ack arriving in the timeout cycle -> normal completion.
- Assert rst in the 2nd ACCESS cycle -> bus_req_o and stall_o are 0 immediately, no pulses. After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: access widths,
// error causes and controller states.
package mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_BUS     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_cause_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // Width 11 is never legal; halves need an even address, words a 4-byte one.
    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic ok;
        case (width)
            W_BYTE:  ok = 1'b1;
            W_HALF:  ok = ~addr_lo[0];
            W_WORD:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes and lane replication, plus load
// extraction and sign/zero extension from the addressed lane.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic        rdtype_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rd_data_o
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case, so no path infers a latch.
    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = wr_data_i;
        rd_data_o = 32'h0;
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        case (width_i)
            W_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wr_data_i[7:0]}};
                rd_data_o = {{24{~rdtype_i & shifted[7]}}, shifted[7:0]};
            end
            W_HALF: begin
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o   = {2{wr_data_i[15:0]}};
                rd_data_o = {{16{~rdtype_i & shifted[15]}}, shifted[15:0]};
            end
            W_WORD: begin
                be_o      = 4'b1111;
                wdata_o   = wr_data_i;
                rd_data_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access sequencer: issues one req/ack bus transaction per
// memory op, stalls the pipeline until it completes, and reports errors.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtype_i,
    input  logic        mem_rw_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] mem_wr_data_i,
    input  logic        mem_rdtype_i,
    input  logic [31:0] mem_addr_i,
    output logic        stall_o,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [1:0]       width_q, width_d, addr_lo_q, addr_lo_d;
    logic             rdtype_q, rdtype_d;
    logic             rd_valid_q, rd_valid_d, err_q, err_d;
    err_cause_e       err_cause_q, err_cause_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic             in_idle;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata, al_rd_data;

    assign in_idle = (state_q == IDLE);

    // One aligner serves both directions: in IDLE it steers the incoming
    // store, in ACCESS it extracts the load using the latched op.
    mem_lane_align u_align (
        .width_i   (in_idle ? mem_width_i : width_q),
        .addr_lo_i (in_idle ? mem_addr_i[1:0] : addr_lo_q),
        .wr_data_i (mem_wr_data_i),
        .rdtype_i  (rdtype_q),
        .rdata_i   (bus_rdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rd_data_o (al_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        width_d     = width_q;
        addr_lo_d   = addr_lo_q;
        rdtype_d    = rdtype_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_d       = 1'b0;
        err_cause_d = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (mtype_i) begin
                    if (is_aligned(mem_width_i, mem_addr_i[1:0])) begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_rw_i;
                        bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_wdata;
                        width_d     = mem_width_i;
                        addr_lo_d   = mem_addr_i[1:0];
                        rdtype_d    = mem_rdtype_i;
                    end else begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        err_cause_d = ERR_ALIGN;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the last allowed cycle wins over the timeout.
                if (bus_ack_i || bus_err_i) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (bus_err_i) begin
                        err_d       = 1'b1;
                        err_cause_d = ERR_BUS;
                    end else if (!bus_we_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = al_rd_data;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    err_d       = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            width_q     <= W_BYTE;
            addr_lo_q   <= 2'b00;
            rdtype_q    <= 1'b0;
            rd_data_q   <= 32'h0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            width_q     <= width_d;
            addr_lo_q   <= addr_lo_d;
            rdtype_q    <= rdtype_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign stall_o     = ~rst & ((in_idle & mtype_i) | (state_q == ACCESS));
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign err_o       = err_q;
    assign err_cause_o = err_cause_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a per-op timeline model predicts every
// output each cycle, plus directed ops with hand-computed expectations.
module tb_mem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mtype_i, mem_rw_i, mem_rdtype_i;
    logic [1:0]  mem_width_i;
    logic [31:0] mem_wr_data_i, mem_addr_i;
    logic        stall_o, rd_valid_o, err_o, bus_req_o, bus_we_o;
    logic [31:0] rd_data_o, bus_addr_o, bus_wdata_o;
    logic [1:0]  err_cause_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mtype_i(mtype_i), .mem_rw_i(mem_rw_i),
        .mem_width_i(mem_width_i), .mem_wr_data_i(mem_wr_data_i),
        .mem_rdtype_i(mem_rdtype_i), .mem_addr_i(mem_addr_i),
        .stall_o(stall_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .err_o(err_o), .err_cause_o(err_cause_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_rv, exp_err, exp_we;
    logic [1:0]  exp_cause;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    int          stall_cnt = 0, req_cnt = 0, s_stall, s_req;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_cause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(input logic [1:0] w, input logic [31:0] a);
        int lo = int'(a % 4);
        return (w == 2'd0) || (w == 2'd1 && lo % 2 == 0) || (w == 2'd2 && lo == 0);
    endfunction

    function automatic int m_bytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] w, input logic [31:0] a);
        int lo = int'(a % 4);
        int nb = m_bytes(w);
        int first = lo - lo % nb;
        logic [3:0] be = 4'h0;
        for (int b = 0; b < 4; b++) if (b >= first && b < first + nb) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'd0) return d[7:0] * 32'h0101_0101;
        if (w == 2'd1) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic [31:0] a,
                                           input logic rdt, input logic [31:0] rdata);
        int lo = int'(a % 4);
        longint span, v;
        if (w == 2'd2) return rdata;
        span = longint'(1) << (8 * m_bytes(w));
        v = (longint'(rdata) >> (8 * lo)) % span;
        if (!rdt && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall_o), 32'(exp_stall));
            check("bus_req", 32'(bus_req_o), 32'(exp_req));
            check("rd_valid", 32'(rd_valid_o), 32'(exp_rv));
            check("err", 32'(err_o), 32'(exp_err));
            check("err_cause", 32'(err_cause_o), 32'(exp_cause));
            check("rd_data", rd_data_o, exp_rd);
            if (exp_req) begin
                check("bus_we", 32'(bus_we_o), 32'(exp_we));
                check("bus_addr", bus_addr_o, exp_addr);
                check("bus_be", 32'(bus_be_o), 32'(exp_be));
                check("bus_wdata", bus_wdata_o, exp_wdata);
            end
            if (stall_o) stall_cnt++;
            if (bus_req_o) begin
                req_cnt++;
                cap_be    = bus_be_o;
                cap_addr  = bus_addr_o;
                cap_wdata = bus_wdata_o;
            end
            if (err_o) cap_cause = err_cause_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mtype_i = 1'b0;
            bus_ack_i = 1'($urandom);
            bus_err_i = 1'($urandom);
            exp_stall = 1'b0; exp_req = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_cause = 2'd0;
            @(posedge clk); #1;
        end
    endtask

    // k = cycle index within ACCESS at which the bus completes (k >= T: never).
    // mode: 0 ack only, 1 err only, 2 ack and err together.
    task automatic run_op(input logic rw, input logic [1:0] w, input logic [31:0] d,
                          input logic rdt, input logic [31:0] a, input logic [31:0] rdata,
                          input int k, input int mode);
        bit legal = m_legal(w, a);
        int nreq;
        logic [1:0] cause;
        s_stall = stall_cnt;
        s_req   = req_cnt;
        mtype_i = 1'b1; mem_rw_i = rw; mem_width_i = w; mem_wr_data_i = d;
        mem_rdtype_i = rdt; mem_addr_i = a;
        bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom); bus_rdata_i = $urandom;
        exp_stall = 1'b1; exp_req = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_cause = 2'd0;
        @(posedge clk); #1;
        if (legal) begin
            nreq  = (k <= T - 1) ? k + 1 : T;
            cause = (k > T - 1) ? 2'd3 : (mode != 0) ? 2'd2 : 2'd0;
            exp_we = rw; exp_addr = a & ~32'h3; exp_be = m_be(w, a); exp_wdata = m_wdata(w, d);
            for (int i = 0; i < nreq; i++) begin
                exp_req = 1'b1; exp_stall = 1'b1;
                bus_ack_i   = (i == k) && (mode != 1);
                bus_err_i   = (i == k) && (mode != 0);
                bus_rdata_i = (i == k) ? rdata : $urandom;
                mem_addr_i = $urandom; mem_wr_data_i = $urandom; mem_width_i = 2'($urandom);
                mem_rdtype_i = 1'($urandom); mem_rw_i = 1'($urandom);
                @(posedge clk); #1;
            end
        end else begin
            cause = 2'd1;
        end
        exp_req = 1'b0; exp_stall = 1'b0;
        exp_err = (cause != 2'd0); exp_cause = cause;
        exp_rv = legal && !rw && cause == 2'd0;
        if (exp_rv) exp_rd = m_load(w, a, rdt, rdata);
        bus_ack_i = 1'($urandom); bus_err_i = 1'($urandom);
        @(posedge clk); #1;
        mtype_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
        exp_rv = 1'b0; exp_err = 1'b0; exp_cause = 2'd0; exp_stall = 1'b0;
    endtask

    initial begin
        logic [1:0] w;
        logic [31:0] a;
        rst = 1'b1; mtype_i = 1'b1; mem_rw_i = 1'b0; mem_width_i = 2'd2; mem_wr_data_i = 32'h0;
        mem_rdtype_i = 1'b0; mem_addr_i = 32'h0; bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;
        exp_rd = 32'h0; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_req", 32'(bus_req_o), 32'd0);
        check("reset_pulses", {30'd0, rd_valid_o, err_o}, 32'd0);
        check("reset_rd_data", rd_data_o, 32'd0);
        check("reset_bus_be", 32'(bus_be_o), 32'd0);
        mtype_i = 1'b0;
        rst = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_cause = 2'd0;
        chk_en = 1'b1;
        idle(2);

        // model pins
        check("pin_m_lb", m_load(2'd0, 32'h1003, 1'b0, 32'h80FF_FF12), 32'hFFFF_FF80);
        check("pin_m_lhu", m_load(2'd1, 32'h2002, 1'b1, 32'hBEEF_1234), 32'h0000_BEEF);
        check("pin_m_sb", m_wdata(2'd0, 32'h0000_005A), 32'h5A5A_5A5A);

        // LB sign-extend, ack one cycle after req
        run_op(1'b0, 2'd0, 32'h0, 1'b0, 32'h0000_1003, 32'h80FF_FF12, 1, 0);
        check("lb_rd_data", rd_data_o, 32'hFFFF_FF80);
        check("lb_be", 32'(cap_be), 32'h8);
        check("lb_stall", 32'(stall_cnt - s_stall), 32'd3);
        idle(1);
        // LHU, immediate ack
        run_op(1'b0, 2'd1, 32'h0, 1'b1, 32'h0000_2002, 32'hBEEF_1234, 0, 0);
        check("lhu_addr", cap_addr, 32'h0000_2000);
        check("lhu_be", 32'(cap_be), 32'hC);
        check("lhu_rd_data", rd_data_o, 32'h0000_BEEF);
        // SW with 3 wait cycles, back-to-back with SB
        run_op(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0, 3, 0);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("sw_req_cycles", 32'(req_cnt - s_req), 32'd4);
        check("sw_stall", 32'(stall_cnt - s_stall), 32'd5);
        run_op(1'b1, 2'd0, 32'h1234_565A, 1'b0, 32'h0000_0101, 32'h0, 0, 0);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        // misaligned half and illegal width
        run_op(1'b1, 2'd1, 32'h0, 1'b0, 32'h0000_0101, 32'h0, 0, 0);
        check("sh_mis_req", 32'(req_cnt - s_req), 32'd0);
        check("sh_mis_stall", 32'(stall_cnt - s_stall), 32'd1);
        check("sh_mis_cause", 32'(cap_cause), 32'd1);
        run_op(1'b0, 2'd3, 32'h0, 1'b0, 32'h0000_0200, 32'h0, 0, 0);
        check("w11_req", 32'(req_cnt - s_req), 32'd0);
        check("w11_cause", 32'(cap_cause), 32'd1);
        // timeout, bus error with ack, ack in the timeout cycle
        run_op(1'b0, 2'd2, 32'h0, 1'b0, 32'h0000_0300, 32'h0, 10, 0);
        check("to_req_cycles", 32'(req_cnt - s_req), 32'(T));
        check("to_cause", 32'(cap_cause), 32'd3);
        run_op(1'b0, 2'd2, 32'h0, 1'b0, 32'h0000_0304, 32'h1111_2222, 1, 2);
        check("berr_cause", 32'(cap_cause), 32'd2);
        check("berr_rd_hold", rd_data_o, 32'h0000_BEEF);
        run_op(1'b0, 2'd2, 32'h0, 1'b0, 32'h0000_0308, 32'h1234_5678, T - 1, 0);
        check("ack_at_to_rd", rd_data_o, 32'h1234_5678);
        check("ack_at_to_req", 32'(req_cnt - s_req), 32'(T));
        idle(2);

        // reset in the second ACCESS cycle
        chk_en = 1'b0;
        mtype_i = 1'b1; mem_rw_i = 1'b0; mem_width_i = 2'd2; mem_addr_i = 32'h400;
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_req", 32'(bus_req_o), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(bus_req_o), 32'd0);
        check("rst_mid_stall", 32'(stall_o), 32'd0);
        check("rst_mid_pulses", {30'd0, rd_valid_o, err_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mtype_i = 1'b0;
        @(posedge clk); #1;
        check("rst_post_pulses", {30'd0, rd_valid_o, err_o, bus_req_o}, 32'd0);
        exp_rd = 32'h0;
        chk_en = 1'b1;
        idle(1);
        run_op(1'b0, 2'd2, 32'h0, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 0, 0);
        check("lw_after_rst", rd_data_o, 32'hCAFE_F00D);

        // randomized ops
        for (int n = 0; n < 300; n++) begin
            w = 2'($urandom);
            if (w == 2'd3 && $urandom_range(0, 3) != 0) w = 2'd2;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((w == 2'd1) ? 32'h1 : (w == 2'd2) ? 32'h3 : 32'h0);
            run_op(1'($urandom), w, $urandom, 1'($urandom), a, $urandom,
                   $urandom_range(0, T + 1), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
